// File: rtl/synth_pkg.sv
// ---------------------------------------------------------------------------
// synth_pkg
// Definitions shared by the MIDI front end and the synthesizer:
//   - layout of the 16-bit note command word {on, note[6:0], velocity[7:0]}
//   - the reserved "stop all" note code
//   - MIDI status nibbles and the controller numbers that silence everything
//   - parser state encoding
//   - helpers to build a command word and classify message lengths
// ---------------------------------------------------------------------------
package synth_pkg;

    // Command word field positions
    localparam int CMD_ON_BIT   = 15;
    localparam int CMD_NOTE_MSB = 14;
    localparam int CMD_NOTE_LSB = 8;
    localparam int CMD_VEL_MSB  = 7;
    localparam int CMD_VEL_LSB  = 0;

    // Note code 127 is reserved as the stop-all marker, never a real note
    localparam logic [6:0] STOP_ALL_NOTE = 7'h7F;

    // MIDI channel-message status nibbles
    localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
    localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
    localparam logic [3:0] MIDI_CC       = 4'hB;
    localparam logic [3:0] MIDI_PROG     = 4'hC;
    localparam logic [3:0] MIDI_CHPRESS  = 4'hD;

    // Controllers that mean "silence everything"
    localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;
    localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

    // Parser states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA1 = 2'd1,
        DATA2 = 2'd2,
        SKIP  = 2'd3
    } parser_state_t;

    // Program change and channel pressure carry a single data byte
    function automatic logic has_one_data_byte(input logic [3:0] status_nibble);
        return (status_nibble == MIDI_PROG) || (status_nibble == MIDI_CHPRESS);
    endfunction

    // Assemble a command word from its fields
    function automatic logic [15:0] make_cmd(input logic       on,
                                             input logic [6:0] note,
                                             input logic [7:0] vel);
        logic [15:0] c;
        c = '0;
        c[CMD_ON_BIT]                = on;
        c[CMD_NOTE_MSB:CMD_NOTE_LSB] = note;
        c[CMD_VEL_MSB:CMD_VEL_LSB]   = vel;
        return c;
    endfunction

endpackage

// File: rtl/midi_cmd_fifo.sv
// ---------------------------------------------------------------------------
// midi_cmd_fifo
// Synchronous 16-bit command FIFO with a first-word-fall-through head.
// Pointers carry one extra bit so full and empty can be told apart.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset (empties FIFO)
//   push, push_data: write one entry (ignored when full)
//   pop            : drop the head entry (ignored when empty)
//   head           : current head entry, valid while !empty
//   count          : number of stored entries
//   empty, full    : occupancy flags
// ---------------------------------------------------------------------------
module midi_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [15:0]   push_data,
    input  logic          pop,
    output logic [15:0]   head,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
);

    logic [15:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Storage needs no reset: nothing reads an entry before it is written.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Pointer update; push and pop may happen on the same edge, which leaves
    // the occupancy unchanged even when only one entry is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/midi_note_master.sv
// ---------------------------------------------------------------------------
// midi_note_master
// Parses a raw MIDI byte stream into 16-bit note commands and issues them as
// Avalon-MM writes to the synthesizer, with a small FIFO absorbing stalls.
// Parameters: CHANNEL (accepted channel), OMNI (accept all channels),
//             FIFO_DEPTH (command entries, power of two, >= 2)
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   asi_snk0_*          : Avalon-ST byte sink (data, valid, ready)
//   avm_m0_write        : write request to the synthesizer slave
//   avm_m0_writedata    : {16'b0, on, note[6:0], velocity[7:0]}
//   avm_m0_waitrequest  : slave stall
//   o_busy              : FIFO holds commands or a message is in progress
// ---------------------------------------------------------------------------
module midi_note_master
    import synth_pkg::*;
#(
    parameter int unsigned CHANNEL    = 0,
    parameter bit          OMNI       = 1'b0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  asi_snk0_data,
    input  logic        asi_snk0_valid,
    output logic        asi_snk0_ready,
    output logic        avm_m0_write,
    output logic [31:0] avm_m0_writedata,
    input  logic        avm_m0_waitrequest,
    output logic        o_busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    parser_state_t state;
    logic [7:0]    run_status;
    logic          run_valid;
    logic [6:0]    data1;

    logic          byte_acc;
    logic          is_status;
    logic          is_realtime;
    logic          chan_ok;
    logic          cmd_ok;
    logic [15:0]   cmd;

    logic          fifo_push;
    logic          fifo_pop;
    logic [15:0]   fifo_head;
    logic [AW:0]   fifo_count;
    logic          fifo_empty;
    logic          fifo_full;

    assign asi_snk0_ready = !reset && !fifo_full;
    assign byte_acc       = asi_snk0_valid && asi_snk0_ready;
    assign is_status      = asi_snk0_data[7];
    assign is_realtime    = (asi_snk0_data[7:3] == 5'b11111);
    assign chan_ok        = OMNI || (run_status[3:0] == 4'(CHANNEL));

    // Decode the command that the incoming byte would complete, using the
    // registered running status and first data byte. Note 127 is dropped on
    // note messages because that code is reserved for stop-all.
    always_comb begin
        cmd    = '0;
        cmd_ok = 1'b0;
        if (chan_ok) begin
            case (run_status[7:4])
                MIDI_NOTE_ON: begin
                    if (data1 != STOP_ALL_NOTE) begin
                        cmd_ok = 1'b1;
                        if (asi_snk0_data[6:0] != 7'd0) begin
                            cmd = make_cmd(1'b1, data1, {1'b0, asi_snk0_data[6:0]});
                        end else begin
                            cmd = make_cmd(1'b0, data1, 8'h00);
                        end
                    end
                end
                MIDI_NOTE_OFF: begin
                    if (data1 != STOP_ALL_NOTE) begin
                        cmd_ok = 1'b1;
                        cmd    = make_cmd(1'b0, data1, 8'h00);
                    end
                end
                MIDI_CC: begin
                    if (data1 == CC_ALL_SOUND_OFF || data1 == CC_ALL_NOTES_OFF) begin
                        cmd_ok = 1'b1;
                        cmd    = make_cmd(1'b0, STOP_ALL_NOTE, 8'h00);
                    end
                end
                default: begin
                    cmd_ok = 1'b0;
                end
            endcase
        end
    end

    // A command is pushed on the same edge that accepts the final data byte.
    // Single-data-byte messages never produce a command, so only DATA2 matters.
    assign fifo_push = byte_acc && !is_status && (state == DATA2) && cmd_ok;
    assign fifo_pop  = avm_m0_write && !avm_m0_waitrequest;

    // Parser FSM. Real-time bytes pass straight through without touching any
    // state. SysEx start parks the parser in SKIP until another non-real-time
    // status byte arrives; a new channel status byte also leaves SKIP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            run_status <= 8'h00;
            run_valid  <= 1'b0;
            data1      <= 7'd0;
        end else if (byte_acc) begin
            if (is_status) begin
                if (!is_realtime) begin
                    if (asi_snk0_data == 8'hF0) begin
                        state     <= SKIP;
                        run_valid <= 1'b0;
                    end else if (asi_snk0_data[7:4] == 4'hF) begin
                        state     <= IDLE;
                        run_valid <= 1'b0;
                    end else begin
                        run_status <= asi_snk0_data;
                        run_valid  <= 1'b1;
                        state      <= has_one_data_byte(asi_snk0_data[7:4]) ? DATA2 : DATA1;
                    end
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (run_valid && !has_one_data_byte(run_status[7:4])) begin
                            data1 <= asi_snk0_data[6:0];
                            state <= DATA2;
                        end
                    end
                    DATA1: begin
                        data1 <= asi_snk0_data[6:0];
                        state <= DATA2;
                    end
                    DATA2: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= SKIP;
                    end
                endcase
            end
        end
    end

    midi_cmd_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_data(cmd),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // Write request: rises one cycle after the FIFO becomes non-empty, holds
    // through waitrequest, and stays high across a pop whenever another entry
    // (possibly one pushed on that same edge) is left to send.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avm_m0_write <= 1'b0;
        end else if (!avm_m0_write) begin
            avm_m0_write <= !fifo_empty;
        end else if (fifo_pop) begin
            avm_m0_write <= !((fifo_count == (AW+1)'(1)) && !fifo_push);
        end
    end

    // The FIFO head only moves on a pop, so it is stable for the whole stall.
    assign avm_m0_writedata = avm_m0_write ? {16'h0000, fifo_head} : 32'h0000_0000;
    assign o_busy           = !fifo_empty || (state != IDLE);

endmodule

// File: tb/tb_midi_note_master.sv
// ---------------------------------------------------------------------------
// tb_midi_note_master
// Directed bench for midi_note_master (CHANNEL=0, OMNI=0, FIFO_DEPTH=4).
// Bytes are driven at the falling edge; a monitor logs every completed write
// a little after the falling edge, and the log is compared to expected words.
// ---------------------------------------------------------------------------
module tb_midi_note_master;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  asi_data;
    logic        asi_valid;
    logic        asi_ready;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_wait;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int cycle        = 0;

    logic [31:0] obs_q[$];
    int          obs_cyc[$];
    logic [31:0] exp_q[$];

    midi_note_master #(
        .CHANNEL   (0),
        .OMNI      (1'b0),
        .FIFO_DEPTH(4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .asi_snk0_data     (asi_data),
        .asi_snk0_valid    (asi_valid),
        .asi_snk0_ready    (asi_ready),
        .avm_m0_write      (avm_write),
        .avm_m0_writedata  (avm_writedata),
        .avm_m0_waitrequest(avm_wait),
        .o_busy            (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Log each accepted write (write high, no stall) once per cycle
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset && avm_write && !avm_wait) begin
                obs_q.push_back(avm_writedata);
                obs_cyc.push_back(cycle);
            end
        end
    end

    // Hard stop in case something never returns
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Present one byte from a falling edge and return right after the rising
    // edge that accepts it; a byte never accepted counts as a failure.
    task automatic applyStimulus(input logic [7:0] b);
        int waited;
        @(negedge clk);
        asi_data  = b;
        asi_valid = 1'b1;
        waited    = 0;
        while (!asi_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!asi_ready) begin
            checkOutput($sformatf("byte_%02h_accept", b), 32'(asi_ready), 32'd1);
            asi_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic goIdle();
        @(negedge clk);
        asi_valid = 1'b0;
    endtask

    task automatic compareWrites(input string tag);
        repeat (12) @(negedge clk);
        checkOutput({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) begin
                checkOutput($sformatf("%s_w%0d", tag, i), obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        obs_cyc.delete();
        exp_q.delete();
    endtask

    initial begin
        reset     = 1'b1;
        asi_data  = 8'h00;
        asi_valid = 1'b0;
        avm_wait  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", 32'(asi_ready), 32'd0);
        checkOutput("rst_write", 32'(avm_write), 32'd0);
        checkOutput("rst_wdata", avm_writedata, 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("rst_release_ready", 32'(asi_ready), 32'd1);

        // Basic note on, with write timing
        applyStimulus(8'h90);
        applyStimulus(8'h3C);
        #1;
        checkOutput("busy_mid_msg", 32'(busy), 32'd1);
        applyStimulus(8'h64);
        goIdle();
        checkOutput("t1_write_not_yet", 32'(avm_write), 32'd0);
        @(negedge clk);
        checkOutput("t1_write_high", 32'(avm_write), 32'd1);
        checkOutput("t1_wdata", avm_writedata, 32'h0000_BC64);
        @(negedge clk);
        checkOutput("t1_write_one_cycle", 32'(avm_write), 32'd0);
        exp_q.push_back(32'h0000_BC64);
        compareWrites("t1");

        // Running status, velocity 0 as note off
        applyStimulus(8'h90);
        applyStimulus(8'h45);
        applyStimulus(8'h40);
        applyStimulus(8'h45);
        applyStimulus(8'h00);
        goIdle();
        exp_q.push_back(32'h0000_C540);
        exp_q.push_back(32'h0000_4500);
        compareWrites("runstat");

        // Real-time byte inside a message
        applyStimulus(8'h90);
        applyStimulus(8'h3C);
        applyStimulus(8'hF8);
        applyStimulus(8'h7F);
        goIdle();
        exp_q.push_back(32'h0000_BC7F);
        compareWrites("rtime");

        // SysEx skipped, stray data discarded, then all-notes-off
        applyStimulus(8'hF0);
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        applyStimulus(8'hF7);
        applyStimulus(8'h3C);
        applyStimulus(8'hB0);
        applyStimulus(8'h7B);
        applyStimulus(8'h00);
        goIdle();
        exp_q.push_back(32'h0000_7F00);
        compareWrites("sysex");

        // Note off, reserved note 127, CC 120, program change, plain CC
        applyStimulus(8'h80);
        applyStimulus(8'h3C);
        applyStimulus(8'h40);
        applyStimulus(8'h90);
        applyStimulus(8'h7F);
        applyStimulus(8'h40);
        applyStimulus(8'hB0);
        applyStimulus(8'h78);
        applyStimulus(8'h00);
        applyStimulus(8'hC0);
        applyStimulus(8'h05);
        applyStimulus(8'h06);
        applyStimulus(8'hB0);
        applyStimulus(8'h07);
        applyStimulus(8'h40);
        goIdle();
        exp_q.push_back(32'h0000_3C00);
        exp_q.push_back(32'h0000_7F00);
        compareWrites("misc");

        // Stall: four commands fill the FIFO, the fifth waits for space
        @(negedge clk);
        avm_wait = 1'b1;
        applyStimulus(8'h90);
        applyStimulus(8'h40);
        applyStimulus(8'h10);
        applyStimulus(8'h41);
        applyStimulus(8'h11);
        applyStimulus(8'h42);
        applyStimulus(8'h12);
        applyStimulus(8'h43);
        applyStimulus(8'h13);
        goIdle();
        checkOutput("stall_ready_low", 32'(asi_ready), 32'd0);
        checkOutput("stall_write_high", 32'(avm_write), 32'd1);
        checkOutput("stall_hold0", avm_writedata, 32'h0000_C010);
        repeat (3) @(negedge clk);
        checkOutput("stall_hold1", avm_writedata, 32'h0000_C010);
        checkOutput("stall_write_still", 32'(avm_write), 32'd1);
        avm_wait = 1'b0;
        applyStimulus(8'h44);
        applyStimulus(8'h14);
        goIdle();
        repeat (10) @(negedge clk);
        for (int i = 1; i < obs_cyc.size(); i++) begin
            checkOutput($sformatf("stall_gap%0d", i), 32'(obs_cyc[i] - obs_cyc[0]), 32'(i));
        end
        exp_q.push_back(32'h0000_C010);
        exp_q.push_back(32'h0000_C111);
        exp_q.push_back(32'h0000_C212);
        exp_q.push_back(32'h0000_C313);
        exp_q.push_back(32'h0000_C414);
        compareWrites("stall");

        // Other channel is ignored
        applyStimulus(8'h91);
        applyStimulus(8'h3C);
        applyStimulus(8'h64);
        goIdle();
        compareWrites("chan1");

        // Reset in the middle of a stalled write
        avm_wait = 1'b1;
        applyStimulus(8'h90);
        applyStimulus(8'h3C);
        applyStimulus(8'h64);
        goIdle();
        repeat (2) @(negedge clk);
        checkOutput("rstmid_pre_write", 32'(avm_write), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("rstmid_write", 32'(avm_write), 32'd0);
        checkOutput("rstmid_wdata", avm_writedata, 32'h0);
        checkOutput("rstmid_ready", 32'(asi_ready), 32'd0);
        checkOutput("rstmid_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        avm_wait = 1'b0;
        #1;
        checkOutput("rstmid_ready_after", 32'(asi_ready), 32'd1);
        checkOutput("rstmid_busy_after", 32'(busy), 32'd0);
        obs_q.delete();
        obs_cyc.delete();

        // Running status was cleared by reset: leading data bytes are dropped
        applyStimulus(8'h3C);
        applyStimulus(8'h64);
        applyStimulus(8'h90);
        applyStimulus(8'h30);
        applyStimulus(8'h20);
        goIdle();
        exp_q.push_back(32'h0000_B020);
        compareWrites("postrst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/midi_note_master.md
# midi_note_master

Converts a raw MIDI byte stream (one byte per Avalon-ST beat, from the UART receiver) into 16-bit note commands. It issues those commands as Avalon-MM writes to the synthesizer's `avs_s0` slave. It is the initiator end of the note-command interface, with a small command FIFO absorbing slave backpressure. It sits between the MIDI UART RX and `synthesizer_top_p` in the Qsys system.

## Interface
- `CHANNEL`, default 0: MIDI channel (0-15) accepted when `OMNI`=0.
- `OMNI`, default 0: 1 accepts all channels.
- `FIFO_DEPTH`, default 4: command FIFO entries, power of two, ≥2.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `asi_snk0_data` in 8: MIDI byte.
- `asi_snk0_valid` in 1: byte valid.
- `asi_snk0_ready` out 1: byte accepted when valid&ready at posedge.
- `avm_m0_write` out 1: write request.
- `avm_m0_writedata` out 32: `{16'b0, on, note[6:0], velocity[7:0]}`.
- `avm_m0_waitrequest` in 1: slave stall.
- `o_busy` out 1: FIFO non-empty or parser mid-message.

## Operation
- **Command word:**
  - bit15 = on.
  - bits14:8 = note.
  - bits7:0 = velocity.
  - Stop-all = `{0, 7'h7F, 8'h00}`.
- **Parser FSM states:** IDLE, DATA1, DATA2, SKIP.
- **Status byte (bit7=1) handling:**
  - 0xF8-0xFF (real-time): ignored in every state; state, running status and data1 are untouched.
  - 0xF0: enter SKIP and clear running status. Leave SKIP on any status byte other than real-time; 0xF7 returns to IDLE.
  - 0xF1-0xF7 (other system common): clear running status and go to IDLE.
  - Channel status 0x80-0xEF: store as running status.
    - 0xCn/0xDn: expect 1 data byte (DATA2 only).
    - All others: expect 2 data bytes (DATA1 then DATA2).
- **Data byte (bit7=0) handling:**
  - In IDLE with a valid running status: treated as the first data byte.
  - In IDLE with no running status: discarded.
  - In SKIP: discarded.
- **Message completion.** When the last data byte is accepted, the FSM returns to IDLE with running status kept. A command is pushed only if the channel matches (or `OMNI`=1):
  - 0x9n with vel≠0: push `{1, note, vel}`.
  - 0x9n with vel=0, or 0x8n: push `{0, note, 8'h00}`.
  - 0xBn with controller 123 or 120: push stop-all.
  - All other messages: no push.
  - Note 127 on 0x8n/0x9n is reserved and dropped.
- **FIFO:** `asi_snk0_ready` = !full, so bytes are never dropped for lack of space.

## Timing
- **Reset values (applied asynchronously):**
  - `avm_m0_write`=0
  - `avm_m0_writedata`=0
  - `asi_snk0_ready`=0 while reset is high, 1 after release
  - `o_busy`=0
  - FSM=IDLE, running status cleared, FIFO empty
- **Push timing:** the command is written into the FIFO at the same posedge that accepts the final data byte, decoded combinationally from the incoming byte plus the registered status/data1.
- **Latency:** `avm_m0_write` rises 1 cycle after the FIFO becomes non-empty. So the final byte accepted at edge N gives write high from N+1.
- **Hold rule:** while write=1 and waitrequest=1, write and writedata stay stable.
- **Pop rule:** the entry pops at the posedge where write=1 and waitrequest=0.
- **Back-to-back writes:** if another entry remains, write stays high and writedata changes to the next entry on that same edge, giving one write per cycle.
- **Simultaneous push and pop:** allowed whenever not full, including when the FIFO holds 1 entry; occupancy is then unchanged.
- **Full FIFO:** ready goes low, and a pop re-enables ready on the next cycle.
- **Pointer wrap:** modulo `FIFO_DEPTH`. Full/empty are distinguished by an extra pointer bit.
- **Reset mid-transaction:** the write is abandoned immediately and the in-progress message is lost.

## Structure
- Shared package `synth_pkg` holds:
  - command field positions
  - `STOP_ALL_NOTE`=7'h7F
  - MIDI status nibble constants (NOTE_OFF=8, NOTE_ON=9, CC=B, PROG=C, CHPRESS=D)
  - CC numbers 120 and 123
- One sub-module, `midi_cmd_fifo`: synchronous FIFO, 16-bit wide, `FIFO_DEPTH` entries, first-word-fall-through head, async reset.
- The parser FSM and Avalon master logic live in `midi_note_master`.

## Test plan
- 0x90 0x3C 0x64 with waitrequest=0 → one write of 0x0000BC64 (note on, note 60, vel 100), write high exactly 1 cycle, starting the cycle after the third byte is accepted.
- Running status: 0x90 0x45 0x40, then 0x45 0x00 → two writes, 0x0000C540 then 0x00004500.
- Bytes 0x90 0x3C 0xF8 0x7F (real-time byte inside the message) → one write of 0x0000BC7F.
- 0xF0 0x01 0x02 0xF7 0x3C, then 0xB0 0x7B 0x00 → the SysEx and the stray 0x3C produce no write, then stop-all 0x00007F00.
- waitrequest held at 1 while 5 note-ons are streamed:
  - 4 entries queue, then ready=0.
  - writedata holds the first command while waitrequest=1.
  - On release, 5 writes complete in order on 5 consecutive cycles.
- 0x91 0x3C 0x64 with `CHANNEL`=0, `OMNI`=0 → no write. Reset asserted during a stalled write → write=0 the same cycle, FIFO empty.
